// File: rtl/ad9648_axil_regs_if.sv
// ad9648_axil_regs_if: AXI4-Lite bus bundle between the control master and the ad9648 register file.
// Signals: write address (awaddr/awprot/awvalid/awready), write data (wdata/wstrb/wvalid/wready),
// write response (bresp/bvalid/bready), read address (araddr/arprot/arvalid/arready),
// read data (rdata/rresp/rvalid/rready). Modports: master drives requests, slave drives responses.
interface ad9648_axil_regs_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/ad9648_axil_regs.sv
// ad9648_axil_regs: AXI4-Lite slave with NUM_REGS byte-strobed 32-bit registers for the ad9648 wrapper.
// Ports: ACLK clock; ARESETN sync active-low reset; s_axi AXI4-Lite slave bundle;
// regs_o flat register contents (reg k at [32k+31:32k]); wr_pulse_o one-cycle per-register write strobe.
module ad9648_axil_regs #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_REGS   = 4
) (
    input  logic                     ACLK,
    input  logic                     ARESETN,
    ad9648_axil_regs_if.slave        s_axi,
    output logic [NUM_REGS*32-1:0]   regs_o,
    output logic [NUM_REGS-1:0]      wr_pulse_o
);
    typedef enum logic [1:0] {W_IDLE, W_NEED_W, W_NEED_AW, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t                    w_state_q, w_state_d;
    r_state_t                    r_state_q, r_state_d;
    logic [NUM_REGS-1:0][31:0]   regs_q, regs_d;
    logic [NUM_REGS-1:0]         wr_pulse_q, wr_pulse_d;
    logic [ADDR_WIDTH-1:0]       awaddr_q, awaddr_d;
    logic [31:0]                 wdata_q, wdata_d;
    logic [3:0]                  wstrb_q, wstrb_d;
    logic [31:0]                 rdata_q, rdata_d;
    logic                        ready_en_q;
    logic                        ready_en;
    logic                        aw_hs, w_hs, ar_hs, commit;
    logic [ADDR_WIDTH-1:0]       c_addr;
    logic [31:0]                 c_data;
    logic [3:0]                  c_strb;
    logic [ADDR_WIDTH-3:0]       w_idx, r_idx;
    logic                        unused_ok;

    // READY is held low for the first cycle after reset release and while ARESETN is low
    assign ready_en       = ready_en_q & ARESETN;
    assign s_axi.awready  = ready_en & (w_state_q == W_IDLE || w_state_q == W_NEED_AW);
    assign s_axi.wready   = ready_en & (w_state_q == W_IDLE || w_state_q == W_NEED_W);
    assign s_axi.bvalid   = w_state_q == W_RESP;
    assign s_axi.bresp    = 2'b00;
    assign s_axi.arready  = ready_en & (r_state_q == R_IDLE);
    assign s_axi.rvalid   = r_state_q == R_DATA;
    assign s_axi.rdata    = rdata_q;
    assign s_axi.rresp    = 2'b00;
    assign regs_o         = regs_q;
    assign wr_pulse_o     = wr_pulse_q;
    assign unused_ok      = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};

    assign aw_hs = s_axi.awvalid & s_axi.awready;
    assign w_hs  = s_axi.wvalid & s_axi.wready;
    assign ar_hs = s_axi.arvalid & s_axi.arready;

    // A beat handshaking this cycle wins over the latched copy of that channel
    assign c_addr = aw_hs ? s_axi.awaddr : awaddr_q;
    assign c_data = w_hs ? s_axi.wdata : wdata_q;
    assign c_strb = w_hs ? s_axi.wstrb : wstrb_q;
    assign w_idx  = c_addr[ADDR_WIDTH-1:2];
    assign r_idx  = s_axi.araddr[ADDR_WIDTH-1:2];

    always_comb begin
        w_state_d  = w_state_q;
        awaddr_d   = aw_hs ? s_axi.awaddr : awaddr_q;
        wdata_d    = w_hs ? s_axi.wdata : wdata_q;
        wstrb_d    = w_hs ? s_axi.wstrb : wstrb_q;
        regs_d     = regs_q;
        wr_pulse_d = '0;
        unique case (w_state_q)
            W_IDLE:    w_state_d = (aw_hs && w_hs) ? W_RESP : aw_hs ? W_NEED_W : w_hs ? W_NEED_AW : W_IDLE;
            W_NEED_W:  w_state_d = w_hs ? W_RESP : W_NEED_W;
            W_NEED_AW: w_state_d = aw_hs ? W_RESP : W_NEED_AW;
            W_RESP:    w_state_d = s_axi.bready ? W_IDLE : W_RESP;
            default:   w_state_d = W_IDLE;
        endcase
        // Entering W_RESP from any other state is exactly the final handshake edge
        commit = (w_state_d == W_RESP) && (w_state_q != W_RESP);
        if (commit) begin
            for (int b = 0; b < 4; b++)
                if (c_strb[b]) regs_d[w_idx][8*b +: 8] = c_data[8*b +: 8];
            wr_pulse_d[w_idx] = 1'b1;
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        unique case (r_state_q)
            R_IDLE: begin
                r_state_d = ar_hs ? R_DATA : R_IDLE;
                rdata_d   = ar_hs ? regs_q[r_idx] : rdata_q;
            end
            R_DATA:  r_state_d = s_axi.rready ? R_IDLE : R_DATA;
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            w_state_q  <= W_IDLE;
            r_state_q  <= R_IDLE;
            regs_q     <= '0;
            wr_pulse_q <= '0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            rdata_q    <= '0;
            ready_en_q <= 1'b0;
        end else begin
            w_state_q  <= w_state_d;
            r_state_q  <= r_state_d;
            regs_q     <= regs_d;
            wr_pulse_q <= wr_pulse_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            rdata_q    <= rdata_d;
            ready_en_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ad9648_axil_regs.sv
// tb_ad9648_axil_regs: scoreboard bench for ad9648_axil_regs (read data and write responses queued at issue).
module tb_ad9648_axil_regs;
    logic         clk = 1'b0;
    logic         ARESETN;
    logic [127:0] regs_o;
    logic [3:0]   wr_pulse_o;
    int           vectors = 0;
    int           errors = 0;
    logic [31:0]  exp_regs [4];
    logic [31:0]  rq [$];
    logic [1:0]   bq [$];
    int           pulse_cnt [4];
    logic [31:0]  held;
    int           p0;

    ad9648_axil_regs_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus ();

    ad9648_axil_regs #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_REGS(4)) dut (
        .ACLK(clk),
        .ARESETN(ARESETN),
        .s_axi(bus),
        .regs_o(regs_o),
        .wr_pulse_o(wr_pulse_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] flat();
        return {exp_regs[3], exp_regs[2], exp_regs[1], exp_regs[0]};
    endfunction

    always @(negedge clk) begin
        if (ARESETN === 1'b1) begin
            if (bus.rvalid && bus.rready) begin
                if (rq.size() == 0) check("r_unexpected", 1, 0);
                else begin
                    check("rdata", bus.rdata, rq.pop_front());
                    check("rresp", bus.rresp, 0);
                end
            end
            if (bus.bvalid && bus.bready) begin
                if (bq.size() == 0) check("b_unexpected", 1, 0);
                else check("bresp", bus.bresp, bq.pop_front());
            end
            for (int k = 0; k < 4; k++) if (wr_pulse_o[k]) pulse_cnt[k]++;
        end
    end

    task automatic write_issue(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                               input int awd, input int wd);
        fork
            begin
                logic hs;
                repeat (awd) cyc();
                bus.awaddr = a;
                bus.awvalid = 1'b1;
                for (int n = 0; ; n++) begin
                    hs = bus.awready;
                    cyc();
                    if (hs) break;
                    if (n > 100) begin check("aw_timeout", 0, 1); break; end
                end
                bus.awvalid = 1'b0;
            end
            begin
                logic hs;
                repeat (wd) cyc();
                bus.wdata = d;
                bus.wstrb = s;
                bus.wvalid = 1'b1;
                for (int n = 0; ; n++) begin
                    hs = bus.wready;
                    cyc();
                    if (hs) break;
                    if (n > 100) begin check("w_timeout", 0, 1); break; end
                end
                bus.wvalid = 1'b0;
            end
        join
        for (int b = 0; b < 4; b++) if (s[b]) exp_regs[a[3:2]][8*b +: 8] = d[8*b +: 8];
        bq.push_back(2'b00);
        check("bvalid_lat", bus.bvalid, 1);
        check("wr_pulse", wr_pulse_o, 4'b0001 << a[3:2]);
        check("regs_o", regs_o, flat());
    endtask

    task automatic write_finish();
        for (int n = 0; bus.bvalid; n++) begin
            if (n > 100) begin check("b_timeout", 0, 1); break; end
            cyc();
        end
    endtask

    task automatic read_issue(input logic [3:0] a);
        logic hs;
        rq.push_back(exp_regs[a[3:2]]);
        bus.araddr = a;
        bus.arvalid = 1'b1;
        for (int n = 0; ; n++) begin
            hs = bus.arready;
            cyc();
            if (hs) break;
            if (n > 100) begin check("ar_timeout", 0, 1); break; end
        end
        bus.arvalid = 1'b0;
        check("rvalid_lat", bus.rvalid, 1);
    endtask

    task automatic read_finish();
        for (int n = 0; bus.rvalid; n++) begin
            if (n > 100) begin check("r_timeout", 0, 1); break; end
            cyc();
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s, input int awd, input int wd);
        write_issue(a, d, s, awd, wd);
        write_finish();
    endtask

    task automatic rd(input logic [3:0] a);
        read_issue(a);
        read_finish();
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin exp_regs[k] = '0; pulse_cnt[k] = 0; end
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b1;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;
        ARESETN = 1'b0;
        repeat (3) cyc();
        check("rst_regs", regs_o, 0);
        check("rst_bvalid", bus.bvalid, 0);
        check("rst_rvalid", bus.rvalid, 0);
        check("rst_awready", bus.awready, 0);
        check("rst_arready", bus.arready, 0);
        ARESETN = 1'b1;
        cyc();

        // aligned AW+W writes and readback
        for (int k = 0; k < 4; k++) wr(4'(k * 4), 32'(k + 1), 4'hF, 0, 0);
        for (int k = 0; k < 4; k++) rd(4'(k * 4));
        check("regs_flat", regs_o, 128'h00000004_00000003_00000002_00000001);

        // AW leads W, then W leads AW (low addr bits set, must be ignored)
        wr(4'h4, 32'hDEADBEEF, 4'hF, 0, 3);
        wr(4'hA, 32'h12345678, 4'hF, 3, 0);
        rd(4'h4);
        rd(4'h9);

        // byte strobes
        p0 = pulse_cnt[0];
        wr(4'h0, 32'hFFFFFFFF, 4'hF, 0, 0);
        wr(4'h0, 32'h000000AA, 4'b0001, 0, 0);
        rd(4'h0);
        check("pulse_twice", pulse_cnt[0] - p0, 2);
        wr(4'h0, 32'h11111111, 4'b0000, 1, 0);
        check("strb0_pulse", pulse_cnt[0] - p0, 3);
        rd(4'h0);

        // backpressure on B and R
        bus.bready = 1'b0;
        bus.rready = 1'b0;
        fork
            write_issue(4'h8, 32'hCAFEF00D, 4'hF, 0, 0);
            read_issue(4'h4);
        join
        held = exp_regs[1];
        for (int n = 0; n < 5; n++) begin
            check("hold_bvalid", bus.bvalid, 1);
            check("hold_rvalid", bus.rvalid, 1);
            check("hold_rdata", bus.rdata, held);
            check("hold_rdy", {bus.awready, bus.wready, bus.arready}, 3'b000);
            cyc();
        end
        bus.bready = 1'b1;
        bus.rready = 1'b1;
        cyc();
        write_finish();
        read_finish();
        rd(4'h8);

        // simultaneous read/write of the same register
        fork
            write_issue(4'hC, 32'h55, 4'hF, 0, 0);
            read_issue(4'hC);
        join
        write_finish();
        read_finish();
        rd(4'hC);

        // reset mid-transaction
        bus.rready = 1'b0;
        read_issue(4'h0);
        bus.awaddr = 4'h4;
        bus.awvalid = 1'b1;
        for (int n = 0; !bus.awready && n < 100; n++) cyc();
        cyc();
        bus.awvalid = 1'b0;
        check("mid_wready", bus.wready, 1);
        check("mid_awready", bus.awready, 0);
        ARESETN = 1'b0;
        #1;
        check("rst_rdy_forced", {bus.awready, bus.wready, bus.arready}, 3'b000);
        cyc();
        cyc();
        rq.delete();
        for (int k = 0; k < 4; k++) exp_regs[k] = '0;
        check("mid_rst_bvalid", bus.bvalid, 0);
        check("mid_rst_rvalid", bus.rvalid, 0);
        check("mid_rst_regs", regs_o, 0);
        bus.rready = 1'b1;
        ARESETN = 1'b1;
        check("post_rst_rdy0", {bus.awready, bus.wready, bus.arready}, 3'b000);
        cyc();
        check("post_rst_rdy1", {bus.awready, bus.wready, bus.arready}, 3'b111);
        wr(4'h4, 32'hA5A5_5A5A, 4'hF, 0, 0);
        rd(4'h4);
        rd(4'h0);

        repeat (2) cyc();
        check("rq_empty", rq.size(), 0);
        check("bq_empty", bq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/ad9648_axil_regs.md
# ad9648_axil_regs

AXI4-Lite slave register file that terminates the control bus driven by the AXI master into the ad9648 wrapper. It provides NUM_REGS 32-bit read/write registers at word-aligned offsets, with byte-lane write strobes. Register contents are exported as a flat bus to the ADC capture logic. It accepts one write and one read outstanding at a time, and the write and read channels operate independently.

## Interface
- DATA_WIDTH, 32, AXI data width; only 32 is supported.
- ADDR_WIDTH, 4, AXI address width; registers are decoded from addr[ADDR_WIDTH-1:2].
- NUM_REGS, 4, register count; must equal 2**(ADDR_WIDTH-2).
- ACLK  in  1  single clock; all logic is on its rising edge.
- ARESETN  in  1  synchronous, active-low reset.
- S_AXI_AWADDR  in  ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte-lane enables.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake.
- S_AXI_BRESP  out  2  always 2'b00 (OKAY).
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake.
- S_AXI_ARADDR  in  ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  always 2'b00.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake.
- regs_o  out  NUM_REGS*32  register contents; register k occupies bits [32k+31:32k].
- wr_pulse_o  out  NUM_REGS  one-cycle strobe marking which register was written.

## Operation
- Write FSM states:
  - W_IDLE: AWREADY=1, WREADY=1.
  - W_NEED_W: address latched; AWREADY=0, WREADY=1.
  - W_NEED_AW: data and strobe latched; AWREADY=1, WREADY=0.
  - W_RESP: AWREADY=0, WREADY=0, BVALID=1.
- Write transitions:
  - W_IDLE with AWVALID&WVALID: commit the write, go to W_RESP.
  - W_IDLE with AWVALID only: go to W_NEED_W.
  - W_IDLE with WVALID only: go to W_NEED_AW.
  - W_NEED_W with WVALID, or W_NEED_AW with AWVALID: commit, go to W_RESP.
  - W_RESP with BREADY: go to W_IDLE.
- Commit: for each lane b where WSTRB[b]=1, reg[idx][8b+7:8b] <= data[8b+7:8b]. Lanes with a 0 strobe are unchanged. wr_pulse_o[idx]=1 for one cycle. wr_pulse_o fires even when WSTRB=0.
- Read FSM states:
  - R_IDLE: ARREADY=1.
  - R_DATA: ARREADY=0, RVALID=1.
- Read transitions:
  - R_IDLE with ARVALID: RDATA <= reg[idx], go to R_DATA.
  - R_DATA with RREADY: go to R_IDLE.
- RDATA is held stable while RVALID=1 and RREADY=0.
- Low address bits [1:0] are ignored. No address is out of range, so there is no SLVERR.
- Reset (ARESETN=0 at a rising edge):
  - All registers, regs_o, wr_pulse_o, BVALID, RVALID and RDATA go to 0.
  - Both FSMs go to idle.
  - All READY outputs are forced to 0 while ARESETN=0.
  - A reset in the middle of a transaction discards it, with no register update and no response.

## Timing
- READY outputs are decoded from FSM state only and never depend combinationally on VALID inputs.
- Write latency:
  - Register update and wr_pulse_o appear the cycle after the final AW/W handshake edge.
  - BVALID rises on that same cycle.
  - Minimum write occupancy is 2 cycles when BREADY is held high.
- Read latency:
  - RVALID rises one cycle after the AR handshake.
  - Minimum read occupancy is 2 cycles when RREADY is held high.
- Simultaneous read and write to the same register on the same edge: the read returns the old value, and the new value is visible to the next read.
- Back-to-back writes: the next AW/W is accepted no earlier than the cycle after the BREADY handshake.
- Back-to-back reads: the next AR is accepted no earlier than the cycle after the RREADY handshake.
- READY outputs are 0 in the first cycle after ARESETN deasserts only if ARESETN was sampled low at that edge; they are 1 from the following idle cycle onward.

## Test plan
- After reset, write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC with AW and W together, then read all four back. Required: RDATA 0x1..0x4, all responses OKAY, regs_o = 0x00000004_00000003_00000002_00000001.
- AW to 0x4 three cycles before W=0xDEADBEEF, then W three cycles before AW on 0x8 with data 0x12345678. Required: each write commits once, BVALID comes 1 cycle after the later handshake, and readback is correct.
- Write 0xFFFFFFFF to 0x0, then write 0x000000AA with WSTRB=4'b0001. Required: register 0 reads 0xFFFFFFAA, and wr_pulse_o[0] pulses twice.
- Hold BREADY=0 and RREADY=0 for 5 cycles. Required: BVALID, RVALID and RDATA stay stable, and AWREADY/WREADY/ARREADY stay 0 until the handshake.
- Issue a read of 0xC and a write of 0x55 to 0xC on the same edge, with 0xC holding 0x4. Required: the read returns 0x4 and a subsequent read returns 0x55.
- Assert ARESETN=0 while in W_NEED_W and while RVALID=1. Required: BVALID=RVALID=0, regs_o=0, and the next full write/read completes normally.
